// File: rtl/hazard_pkg.sv
// Shared types and helpers for the pipeline hazard unit: forward selects,
// memory wait-state encoding and the register-compare rule.
package hazard_pkg;

  localparam int REG_W = 5;

  typedef enum logic [1:0] {
    FWD_NONE = 2'b00,
    FWD_W    = 2'b01,
    FWD_M    = 2'b10
  } fwd_t;

  typedef enum logic [1:0] {
    IDLE = 2'b00,
    WAIT = 2'b01,
    DONE = 2'b10
  } memst_t;

  // $0 is hardwired, so it never counts as a dependency
  function automatic logic reg_match(input logic [REG_W-1:0] src,
                                     input logic [REG_W-1:0] dst);
    return (src != {REG_W{1'b0}}) && (src == dst);
  endfunction

  // M-stage result is newer than W-stage, so it wins
  function automatic fwd_t fwd_sel(input logic [REG_W-1:0] src,
                                   input logic             regwritem,
                                   input logic [REG_W-1:0] writeregm,
                                   input logic             regwritew,
                                   input logic [REG_W-1:0] writeregw);
    fwd_t sel;
    if (regwritem && reg_match(src, writeregm)) begin
      sel = FWD_M;
    end else if (regwritew && reg_match(src, writeregw)) begin
      sel = FWD_W;
    end else begin
      sel = FWD_NONE;
    end
    return sel;
  endfunction

endpackage

// File: rtl/hazard_unit_if.sv
// Pipeline <-> hazard unit control bundle: stage register ids and enables in,
// stall/flush/forward controls out.
interface hazard_unit_if;
  import hazard_pkg::*;

  logic [REG_W-1:0] rsd;
  logic [REG_W-1:0] rtd;
  logic [REG_W-1:0] rse;
  logic [REG_W-1:0] rte;
  logic [REG_W-1:0] writerege;
  logic [REG_W-1:0] writeregm;
  logic [REG_W-1:0] writeregw;
  logic             regwritee;
  logic             regwritem;
  logic             regwritew;
  logic             memtorege;
  logic             memtoregm;
  logic             memwritem;
  logic             branchd;
  logic             pcsrcd;

  logic             stallf;
  logic             stalld;
  logic             flushd;
  logic             stalle;
  logic             stallm;
  logic             stallw;
  logic             flushe;
  logic             forwardad;
  logic             forwardbd;
  fwd_t             forwardae;
  fwd_t             forwardbe;
  logic             membusy;

  modport master (
    output rsd, rtd, rse, rte, writerege, writeregm, writeregw,
           regwritee, regwritem, regwritew, memtorege, memtoregm,
           memwritem, branchd, pcsrcd,
    input  stallf, stalld, flushd, stalle, stallm, stallw, flushe,
           forwardad, forwardbd, forwardae, forwardbe, membusy
  );

  modport slave (
    input  rsd, rtd, rse, rte, writerege, writeregm, writeregw,
           regwritee, regwritem, regwritew, memtorege, memtoregm,
           memwritem, branchd, pcsrcd,
    output stallf, stalld, flushd, stalle, stallm, stallw, flushe,
           forwardad, forwardbd, forwardae, forwardbe, membusy
  );

endinterface

// File: rtl/hazard_unit_mem_wait_fsm.sv
// Wait-state sequencer for multi-cycle data-memory accesses: holds the pipe for
// MEM_LAT-1 cycles per access, then spends one DONE cycle with the access still in M.
module mem_wait_fsm
  import hazard_pkg::*;
#(
  parameter int MEM_LAT = 1
) (
  input  logic clk,
  input  logic reset,
  input  logic acc,
  output logic memstall,
  output logic membusy
);

  localparam int CNT_W  = (MEM_LAT > 2) ? $clog2(MEM_LAT) : 1;
  localparam int LOAD_I = (MEM_LAT > 2) ? (MEM_LAT - 2) : 0;
  localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'(LOAD_I);
  localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);
  localparam logic [CNT_W-1:0] CNT_ZERO = {CNT_W{1'b0}};
  localparam logic LAT_GT1 = (MEM_LAT > 1) ? 1'b1 : 1'b0;
  localparam logic LAT_GT2 = (MEM_LAT > 2) ? 1'b1 : 1'b0;

  memst_t           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             stall_raw;

  // next-state, counter and stall decode
  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    stall_raw = 1'b0;
    case (state_q)
      IDLE: begin
        if (acc && LAT_GT1) begin
          stall_raw = 1'b1;
          cnt_d     = CNT_LOAD;
          state_d   = LAT_GT2 ? WAIT : DONE;
        end else begin
          state_d = IDLE;
        end
      end
      WAIT: begin
        stall_raw = 1'b1;
        cnt_d     = cnt_q - CNT_ONE;
        if (cnt_q == CNT_ONE) begin
          state_d = DONE;
        end else begin
          state_d = WAIT;
        end
      end
      // DONE ignores acc: the access that just finished is still sitting in M
      DONE: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
        cnt_d   = CNT_ZERO;
      end
    endcase
    memstall = stall_raw & ~reset;
    membusy  = (state_q != IDLE) & ~reset;
  end

  // state and counter registers
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= IDLE;
      cnt_q   <= CNT_ZERO;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

endmodule

// File: rtl/hazard_unit.sv
// Hazard unit for the five-stage pipeline: forwarding selects, load-use and
// branch interlocks, and memory wait-state stalls, all visible in the same cycle.
module hazard_unit
  import hazard_pkg::*;
#(
  parameter int MEM_LAT = 1
) (
  input logic         clk,
  input logic         reset,
  hazard_unit_if.slave hif
);

  logic acc;
  logic memstall;
  logic membusy;
  logic lwstall;
  logic brstall;
  logic stall_fd;

  assign acc = hif.memtoregm | hif.memwritem;

  mem_wait_fsm #(
    .MEM_LAT (MEM_LAT)
  ) u_mem_wait_fsm (
    .clk      (clk),
    .reset    (reset),
    .acc      (acc),
    .memstall (memstall),
    .membusy  (membusy)
  );

  // hazard detection and output equations; memstall dominates any bubble or flush
  always_comb begin
    lwstall = hif.memtorege &
              (reg_match(hif.rte, hif.rsd) | reg_match(hif.rte, hif.rtd));
    brstall = hif.branchd &
              ((hif.regwritee & (reg_match(hif.writerege, hif.rsd) |
                                 reg_match(hif.writerege, hif.rtd))) |
               (hif.memtoregm & (reg_match(hif.writeregm, hif.rsd) |
                                 reg_match(hif.writeregm, hif.rtd))));
    stall_fd = memstall | lwstall | brstall;

    if (reset) begin
      hif.stallf    = 1'b0;
      hif.stalld    = 1'b0;
      hif.flushd    = 1'b0;
      hif.stalle    = 1'b0;
      hif.stallm    = 1'b0;
      hif.stallw    = 1'b0;
      hif.flushe    = 1'b0;
      hif.forwardad = 1'b0;
      hif.forwardbd = 1'b0;
      hif.forwardae = FWD_NONE;
      hif.forwardbe = FWD_NONE;
      hif.membusy   = 1'b0;
    end else begin
      hif.stallf    = stall_fd;
      hif.stalld    = stall_fd;
      hif.flushd    = hif.pcsrcd & ~stall_fd;
      hif.stalle    = memstall;
      hif.stallm    = memstall;
      hif.stallw    = memstall;
      hif.flushe    = (lwstall | brstall) & ~memstall;
      hif.forwardad = hif.regwritem & reg_match(hif.rsd, hif.writeregm);
      hif.forwardbd = hif.regwritem & reg_match(hif.rtd, hif.writeregm);
      hif.forwardae = fwd_sel(hif.rse, hif.regwritem, hif.writeregm,
                              hif.regwritew, hif.writeregw);
      hif.forwardbe = fwd_sel(hif.rte, hif.regwritem, hif.writeregm,
                              hif.regwritew, hif.writeregw);
      hif.membusy   = membusy;
    end
  end

endmodule

// File: tb/tb_hazard_unit.sv
// Directed bench for hazard_unit with three memory latencies (1, 4, 5) sharing one
// input stimulus; expected values are hand-derived.
module tb_hazard_unit;
  import hazard_pkg::*;

  logic clk = 1'b0;
  logic reset;
  logic [4:0] rsd, rtd, rse, rte, writerege, writeregm, writeregw;
  logic regwritee, regwritem, regwritew, memtorege, memtoregm, memwritem, branchd, pcsrcd;

  int checks = 0;
  int failures = 0;

  always #5 clk = ~clk;

  hazard_unit_if i1 ();
  hazard_unit_if i4 ();
  hazard_unit_if i5 ();

  assign {i1.rsd, i1.rtd, i1.rse, i1.rte, i1.writerege, i1.writeregm, i1.writeregw, i1.regwritee, i1.regwritem, i1.regwritew, i1.memtorege, i1.memtoregm, i1.memwritem, i1.branchd, i1.pcsrcd} = {rsd, rtd, rse, rte, writerege, writeregm, writeregw, regwritee, regwritem, regwritew, memtorege, memtoregm, memwritem, branchd, pcsrcd};
  assign {i4.rsd, i4.rtd, i4.rse, i4.rte, i4.writerege, i4.writeregm, i4.writeregw, i4.regwritee, i4.regwritem, i4.regwritew, i4.memtorege, i4.memtoregm, i4.memwritem, i4.branchd, i4.pcsrcd} = {rsd, rtd, rse, rte, writerege, writeregm, writeregw, regwritee, regwritem, regwritew, memtorege, memtoregm, memwritem, branchd, pcsrcd};
  assign {i5.rsd, i5.rtd, i5.rse, i5.rte, i5.writerege, i5.writeregm, i5.writeregw, i5.regwritee, i5.regwritem, i5.regwritew, i5.memtorege, i5.memtoregm, i5.memwritem, i5.branchd, i5.pcsrcd} = {rsd, rtd, rse, rte, writerege, writeregm, writeregw, regwritee, regwritem, regwritew, memtorege, memtoregm, memwritem, branchd, pcsrcd};

  hazard_unit #(.MEM_LAT(1)) dut1 (.clk(clk), .reset(reset), .hif(i1));
  hazard_unit #(.MEM_LAT(4)) dut4 (.clk(clk), .reset(reset), .hif(i4));
  hazard_unit #(.MEM_LAT(5)) dut5 (.clk(clk), .reset(reset), .hif(i5));

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic cyc();
    @(posedge clk);
    #2;
  endtask

  task automatic clear_inputs();
    {rsd, rtd, rse, rte, writerege, writeregm, writeregw} = {35{1'b0}};
    {regwritee, regwritem, regwritew, memtorege, memtoregm, memwritem, branchd, pcsrcd} = 8'h00;
  endtask

  initial begin
    clear_inputs();
    reset = 1'b1;
    // hazards present during reset must not leak out
    regwritem = 1'b1; writeregm = 5'd8; rse = 5'd8; memtoregm = 1'b1;
    memtorege = 1'b1; rte = 5'd5; rsd = 5'd5;
    cyc(); cyc();
    #1;
    chk("rst_fwdae", i4.forwardae, 32'd0);
    chk("rst_stallm", i4.stallm, 32'd0);
    chk("rst_stallf", i1.stallf, 32'd0);
    chk("rst_flushe", i1.flushe, 32'd0);
    chk("rst_membusy", i4.membusy, 32'd0);

    cyc();
    reset = 1'b0;
    clear_inputs();
    // E-stage forwarding priority
    regwritem = 1'b1; writeregm = 5'd8; regwritew = 1'b1; writeregw = 5'd8; rse = 5'd8;
    #1;
    chk("fwdae_m", i1.forwardae, 32'd2);
    writeregm = 5'd9;
    #1;
    chk("fwdae_w", i1.forwardae, 32'd1);
    rte = 5'd9;
    #1;
    chk("fwdbe_m", i1.forwardbe, 32'd2);
    rse = 5'd0; writeregw = 5'd0;
    #1;
    chk("fwdae_r0", i1.forwardae, 32'd0);
    chk("stall_none", i1.stallf, 32'd0);

    // load-use, single-cycle memory
    cyc();
    clear_inputs();
    memtorege = 1'b1; rte = 5'd5; rsd = 5'd5;
    #1;
    chk("lw_stallf", i1.stallf, 32'd1);
    chk("lw_stalld", i1.stalld, 32'd1);
    chk("lw_flushe", i1.flushe, 32'd1);
    chk("lw_stalle", i1.stalle, 32'd0);
    cyc();
    clear_inputs();
    #1;
    chk("lw_release", i1.stallf, 32'd0);

    // branch on an E-stage producer, then the same producer in M as ALU op
    cyc();
    branchd = 1'b1; regwritee = 1'b1; writerege = 5'd3; rtd = 5'd3; pcsrcd = 1'b1;
    #1;
    chk("br_stalld", i1.stalld, 32'd1);
    chk("br_flushe", i1.flushe, 32'd1);
    chk("br_flushd", i1.flushd, 32'd0);
    cyc();
    regwritee = 1'b0; writerege = 5'd0; regwritem = 1'b1; writeregm = 5'd3;
    #1;
    chk("br_fwdbd", i1.forwardbd, 32'd1);
    chk("br_fwdad", i1.forwardad, 32'd0);
    chk("br_nostall", i1.stalld, 32'd0);
    chk("br_flushd_taken", i1.flushd, 32'd1);

    // multi-cycle load overlapping a load-use hazard and a taken branch
    cyc();
    clear_inputs();
    cyc();
    memtoregm = 1'b1; memtorege = 1'b1; rte = 5'd5; rsd = 5'd5; pcsrcd = 1'b1;
    #1;
    chk("m4_c0_stallm", i4.stallm, 32'd1);
    chk("m4_c0_stallf", i4.stallf, 32'd1);
    chk("m4_c0_flushe", i4.flushe, 32'd0);
    chk("m4_c0_flushd", i4.flushd, 32'd0);
    chk("m4_c0_busy", i4.membusy, 32'd0);
    chk("m1_c0_stallm", i1.stallm, 32'd0);
    chk("m1_c0_flushe", i1.flushe, 32'd1);
    cyc();
    #1;
    chk("m4_c1_stalle", i4.stalle, 32'd1);
    chk("m4_c1_busy", i4.membusy, 32'd1);
    cyc();
    #1;
    chk("m4_c2_stallw", i4.stallw, 32'd1);
    cyc();
    #1;
    chk("m4_done_stallm", i4.stallm, 32'd0);
    chk("m4_done_flushe", i4.flushe, 32'd1);
    chk("m4_done_stalld", i4.stalld, 32'd1);
    chk("m4_done_busy", i4.membusy, 32'd1);
    chk("m5_c3_stallm", i5.stallm, 32'd1);
    cyc();
    clear_inputs();
    #1;
    chk("m4_idle_busy", i4.membusy, 32'd0);
    chk("m4_idle_stallm", i4.stallm, 32'd0);
    chk("m5_done_stallm", i5.stallm, 32'd0);
    cyc();

    // reset while MEM_LAT=5 is waiting
    cyc();
    memtoregm = 1'b1;
    #1;
    chk("m5_c0_stallm", i5.stallm, 32'd1);
    cyc();
    #1;
    chk("m5_c1_stallm", i5.stallm, 32'd1);
    chk("m5_c1_busy", i5.membusy, 32'd1);
    cyc();
    reset = 1'b1; regwritem = 1'b1; writeregm = 5'd8; rse = 5'd8;
    #1;
    chk("m5_rst_stallm", i5.stallm, 32'd0);
    chk("m5_rst_stallf", i5.stallf, 32'd0);
    chk("m5_rst_busy", i5.membusy, 32'd0);
    chk("m5_rst_fwdae", i5.forwardae, 32'd0);
    cyc();
    reset = 1'b0;
    clear_inputs();
    #1;
    chk("m5_post_stallm", i5.stallm, 32'd0);
    chk("m5_post_busy", i5.membusy, 32'd0);
    cyc();
    #1;
    chk("m5_post2_stallf", i5.stallf, 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/hazard_unit.md
# hazard_unit

Producer of the pipeline-control handshake for the five-stage MIPS datapath: stall, flush and forward signals. It drives the `stalle`/`stallm`/`stallw`/`flushe` inputs of the control pipeline, plus the fetch/decode stalls, decode flush and datapath forwarding muxes. It combines combinational hazard detection with a sequential wait-state FSM that freezes the pipe for multi-cycle data-memory accesses.

## Interface
- `MEM_LAT`, 1, data-memory access latency in cycles (≥1); 1 means no memory stalls
- `clk`  in  1  clock
- `reset`  in  1  synchronous, active-high reset
- `rsd`, `rtd`  in  5 each  source registers of the instruction in D
- `rse`, `rte`  in  5 each  source registers of the instruction in E
- `writerege`, `writeregm`, `writeregw`  in  5 each  destination register in E/M/W
- `regwritee`, `regwritem`, `regwritew`  in  1 each  register-write enables in E/M/W
- `memtorege`, `memtoregm`  in  1 each  load in E/M
- `memwritem`  in  1  store in M
- `branchd`  in  1  branch in D
- `pcsrcd`  in  1  branch taken, resolved in D
- `stallf`, `stalld`  out  1 each  hold PC and the IF/ID register
- `flushd`  out  1  clear the IF/ID register
- `stalle`, `stallm`, `stallw`  out  1 each  hold the ID/EX, EX/MEM and MEM/WB registers
- `flushe`  out  1  clear the ID/EX register (bubble)
- `forwardad`, `forwardbd`  out  1 each  D-stage comparator operand from the M-stage ALU result
- `forwardae`, `forwardbe`  out  2 each  E-stage ALU operand select
- `membusy`  out  1  FSM not in IDLE (debug/perf)

## Operation
- Register 0 never matches. Every register compare includes `!= 0`.
- **Forwarding, E stage.** `forwardae` = FWD_M when `regwritem` and `writeregm == rse`. Otherwise FWD_W when `regwritew` and `writeregw == rse`. Otherwise FWD_NONE. M takes priority over W. `forwardbe` uses the same rule with `rte`.
- **Forwarding, D stage.** `forwardad = regwritem & writeregm == rsd`. `forwardbd` uses the same rule with `rtd`.
- **Load-use hazard.** `lwstall = memtorege & (rte == rsd | rte == rtd)`.
- **Branch hazard.** `brstall = branchd & ((regwritee & writerege ∈ {rsd, rtd}) | (memtoregm & writeregm ∈ {rsd, rtd}))`.
- **Memory FSM.** Let `acc = memtoregm | memwritem`.
  - IDLE: if `acc` and MEM_LAT > 1, assert `memstall` and load `cnt ← MEM_LAT-2`. Go to WAIT if MEM_LAT > 2, otherwise to DONE.
  - WAIT: assert `memstall` and decrement `cnt`. Go to DONE when `cnt == 1`.
  - DONE: no stall, and `acc` is ignored because the same instruction is still in M. Always return to IDLE.
  - Each access therefore gets MEM_LAT-1 stall cycles and occupies M for MEM_LAT cycles.
- **Output equations.**
  - `stallm = stallw = stalle = memstall`
  - `stallf = stalld = memstall | lwstall | brstall`
  - `flushe = (lwstall | brstall) & !memstall`
  - `flushd = pcsrcd & !stalld`
- **Simultaneous events.** `memstall` dominates. While it is asserted, no bubble is inserted, and the load-use and branch conditions are re-evaluated after release. A taken branch with a pending hazard is not flushed until the stall clears.
- **Reset.** While `reset` is high:
  - all outputs are forced to 0, with forwards at FWD_NONE and `membusy` at 0;
  - the FSM goes to IDLE and `cnt` to 0.
  - A reset during WAIT aborts the access; there is no stall in the cycle after reset deasserts unless a new `acc` is present.

## Timing
- All outputs are combinational from the current inputs plus registered FSM state, so they take effect in the same cycle. Downstream pipeline registers sample them at the next `posedge clk`.
- The FSM state and `cnt` update on `posedge clk`.
- Worked example, MEM_LAT = 3, load enters M at cycle 0:
  - stalls high in cycles 0–1;
  - cycle 2 is DONE with stalls low;
  - the load advances to W at the edge ending cycle 2.
- Back-to-back accesses: the second access, entering M at the end of DONE, is detected in the following IDLE cycle.
- Load-use adds exactly one bubble.
- A branch depending on a load in E adds two stall cycles: one for `regwritee` in E, one for `memtoregm` in M.

## Structure
- Shared package `hazard_pkg`:
  - `fwd_t` with FWD_NONE = 2'b00, FWD_W = 2'b01, FWD_M = 2'b10;
  - `memst_t` enum {IDLE, WAIT, DONE};
  - register-address width constant 5.
- One sub-module `mem_wait_fsm` (inputs `clk`, `reset`, `acc`; outputs `memstall`, `membusy`; parameter MEM_LAT). The rest of the block is combinational in `hazard_unit`.

## Test plan
- Forwarding: `regwritem = 1`, `writeregm = 8`, `regwritew = 1`, `writeregw = 8`, `rse = 8` → `forwardae = 2'b10`. Set `writeregm = 9` → `2'b01`. Set `rse = 0` with `writeregw = 0` → `2'b00`.
- Load-use: `memtorege = 1`, `rte = 5`, `rsd = 5`, MEM_LAT = 1 → `stallf = stalld = flushe = 1` for 1 cycle, `stalle = 0`.
- Memory latency, MEM_LAT = 4, `acc` held for the instruction → `stallm/stallw/stalle/stallf/stalld` high for 3 cycles, low in DONE, FSM back in IDLE after 4 cycles. With MEM_LAT = 1 → no stall ever.
- Overlap: load-use condition present during `memstall` → `flushe = 0` while stalled, and `flushe = 1` in the first cycle after release. `pcsrcd = 1` with `brstall = 1` → `flushd = 0`.
- Branch: `branchd = 1`, `regwritee = 1`, `writerege = 3`, `rtd = 3` → stall plus `flushe`. When the producer is in M as an ALU op → `forwardbd = 1`, no stall.
- Reset mid-WAIT, MEM_LAT = 5, reset in cycle 2 → all outputs 0 in the reset cycle, `membusy = 0` afterwards, no residual stall with `acc = 0`.
